// File: rtl/fp_csr_unit.sv
// fp_csr_unit: executes Zicsr accesses to fflags/frm/fcsr and accumulates
// sticky FPU exception flags. It resolves the dynamic rounding mode and
// drives the downstream FCSR holding register.
// Ports:
//   clock, reset                 - clock, async active-low reset
//   csr_valid/addr/op/wdata      - CSR request (one per cycle max)
//   csr_rvalid/rdata/illegal     - registered response, one cycle later
//   fpu_valid, fpu_flags         - retiring FPU op and its {NV,DZ,OF,UF,NX}
//   instr_rm, rm_out, rm_illegal - rounding-mode resolution (combinational)
//   frm, NV..NX, reserved        - FCSR holding-register inputs
//   fs_dirty                     - one-cycle pulse after any state change
module fp_csr_unit #(
    parameter int unsigned RESP_LATENCY = 1,
    parameter logic [23:0] RESERVED_VAL = 24'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        csr_valid,
    input  logic [11:0] csr_addr,
    input  logic [2:0]  csr_op,
    input  logic [31:0] csr_wdata,
    output logic        csr_rvalid,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        fpu_valid,
    input  logic [4:0]  fpu_flags,
    input  logic [2:0]  instr_rm,
    output logic [2:0]  rm_out,
    output logic        rm_illegal,
    output logic [2:0]  frm,
    output logic        NV,
    output logic        DZ,
    output logic        OF,
    output logic        UF,
    output logic        NX,
    output logic [23:0] reserved,
    output logic        fs_dirty
);

    localparam int unsigned FLAGS_W = 5;
    localparam int unsigned FRM_W   = 3;
    localparam int unsigned FCSR_W  = FLAGS_W + FRM_W;

    localparam logic [11:0] ADDR_FFLAGS = 12'h001;
    localparam logic [11:0] ADDR_FRM    = 12'h002;
    localparam logic [11:0] ADDR_FCSR   = 12'h003;

    // Only single-cycle response latency is implemented.
    localparam bit LAT_OK = (RESP_LATENCY == 32'd1);

    logic [FRM_W-1:0]   frm_q;
    logic [FLAGS_W-1:0] fflags_q;
    logic [FRM_W-1:0]   frm_next;
    logic [FLAGS_W-1:0] fflags_next;
    logic [FCSR_W-1:0]  old_val;
    logic [FCSR_W-1:0]  new_val;
    logic               req_legal;
    logic               wr_en;

    // Request decode, read mux and read-modify-write of the addressed field.
    always_comb begin
        req_legal = 1'b0;
        old_val   = '0;
        new_val   = '0;
        wr_en     = 1'b0;

        unique case (csr_addr)
            ADDR_FFLAGS: begin
                req_legal = 1'b1;
                old_val   = FCSR_W'({3'b0, fflags_q});
            end
            ADDR_FRM: begin
                req_legal = 1'b1;
                old_val   = FCSR_W'({5'b0, frm_q});
            end
            ADDR_FCSR: begin
                req_legal = 1'b1;
                old_val   = {frm_q, fflags_q};
            end
            default: req_legal = 1'b0;
        endcase

        // funct3 0 and 4 are not CSR accesses
        if (csr_op[1:0] == 2'd0) begin
            req_legal = 1'b0;
            old_val   = '0;
        end

        unique case (csr_op[1:0])
            2'd1:    new_val = csr_wdata[FCSR_W-1:0];
            2'd2:    new_val = old_val | csr_wdata[FCSR_W-1:0];
            2'd3:    new_val = old_val & ~csr_wdata[FCSR_W-1:0];
            default: new_val = old_val;
        endcase

        // Set/clear with a zero operand is a pure read
        wr_en = csr_valid && req_legal
             && ((csr_op[1:0] == 2'd1) || (csr_wdata != 32'd0));
    end

    // Next-state: CSR write first, then the (older) FPU flags ORed on top.
    always_comb begin
        frm_next    = frm_q;
        fflags_next = fflags_q;

        if (wr_en) begin
            unique case (csr_addr)
                ADDR_FFLAGS: fflags_next = new_val[FLAGS_W-1:0];
                ADDR_FRM:    frm_next    = new_val[FRM_W-1:0];
                ADDR_FCSR: begin
                    frm_next    = new_val[FCSR_W-1:FLAGS_W];
                    fflags_next = new_val[FLAGS_W-1:0];
                end
                default: ;
            endcase
        end

        if (fpu_valid) begin
            fflags_next = fflags_next | fpu_flags;
        end
    end

    // Architectural state and registered response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frm_q       <= '0;
            fflags_q    <= '0;
            csr_rvalid  <= 1'b0;
            csr_rdata   <= '0;
            csr_illegal <= 1'b0;
            fs_dirty    <= 1'b0;
        end else begin
            frm_q       <= frm_next;
            fflags_q    <= fflags_next;
            csr_rvalid  <= csr_valid & LAT_OK;
            csr_rdata   <= (csr_valid && req_legal) ? 32'(old_val) : 32'd0;
            csr_illegal <= csr_valid & ~req_legal;
            fs_dirty    <= (frm_next != frm_q) || (fflags_next != fflags_q);
        end
    end

    // Dynamic rounding mode resolves to frm; 5..7 are reserved encodings.
    always_comb begin
        rm_out     = (instr_rm == 3'b111) ? frm_q : instr_rm;
        rm_illegal = (rm_out >= 3'd5);
    end

    assign frm                  = frm_q;
    assign {NV, DZ, OF, UF, NX} = fflags_q;
    assign reserved             = RESERVED_VAL;

endmodule

// File: tb/tb_fp_csr_unit.sv
// Self-checking bench for fp_csr_unit: directed steps followed by random
// traffic, checked against a byte-wide fcsr model updated with masks/shifts.
module tb_fp_csr_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        csr_valid = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [2:0]  csr_op = '0;
    logic [31:0] csr_wdata = '0;
    logic        csr_rvalid;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        fpu_valid = 1'b0;
    logic [4:0]  fpu_flags = '0;
    logic [2:0]  instr_rm = '0;
    logic [2:0]  rm_out;
    logic        rm_illegal;
    logic [2:0]  frm;
    logic        NV, DZ, OF, UF, NX;
    logic [23:0] reserved;
    logic        fs_dirty;

    int checks = 0;
    int failures = 0;

    // Model: whole fcsr as one byte, frm in [7:5], fflags in [4:0]
    bit [7:0] fcsr_m = 8'h00;

    fp_csr_unit #(.RESP_LATENCY(1), .RESERVED_VAL(24'h0)) dut (
        .clock(clock), .reset(reset),
        .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_rvalid(csr_rvalid), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal), .fpu_valid(fpu_valid), .fpu_flags(fpu_flags),
        .instr_rm(instr_rm), .rm_out(rm_out), .rm_illegal(rm_illegal),
        .frm(frm), .NV(NV), .DZ(DZ), .OF(OF), .UF(UF), .NX(NX),
        .reserved(reserved), .fs_dirty(fs_dirty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".frm"}, 32'(frm), 32'(fcsr_m[7:5]));
        check({tag, ".flags"}, 32'({NV, DZ, OF, UF, NX}), 32'(fcsr_m[4:0]));
    endtask

    // One clock: drive a request (+ optional FPU retire), update the model,
    // then check the response, state and fs_dirty after the edge.
    task automatic step(input string tag, input bit v, input logic [11:0] a,
                        input logic [2:0] op, input logic [31:0] wd,
                        input bit fv, input logic [4:0] ff);
        bit [7:0]  prev;
        bit [7:0]  mask;
        int        sh;
        bit        legal;
        bit [31:0] old_v;
        bit [31:0] new_v;
        bit        do_wr;
        @(negedge clock);
        csr_valid = v; csr_addr = a; csr_op = op; csr_wdata = wd;
        fpu_valid = fv; fpu_flags = ff;

        prev  = fcsr_m;
        legal = 1'b1;
        mask  = 8'h00;
        sh    = 0;
        case (a)
            12'h001: begin mask = 8'h1F; sh = 0; end
            12'h002: begin mask = 8'h07; sh = 5; end
            12'h003: begin mask = 8'hFF; sh = 0; end
            default: legal = 1'b0;
        endcase
        if (op == 3'd0 || op == 3'd4) legal = 1'b0;
        old_v = 32'((fcsr_m >> sh) & mask);
        new_v = old_v;
        do_wr = 1'b0;
        case (op)
            3'd1, 3'd5: begin new_v = wd; do_wr = 1'b1; end
            3'd2, 3'd6: begin new_v = old_v | wd; do_wr = (wd != 0); end
            3'd3, 3'd7: begin new_v = old_v & ~wd; do_wr = (wd != 0); end
            default: ;
        endcase
        if (v && legal && do_wr)
            fcsr_m = (fcsr_m & ~(mask << sh)) | ((8'(new_v) & mask) << sh);
        if (fv) fcsr_m = fcsr_m | {3'b0, ff};

        @(posedge clock);
        #1;
        check({tag, ".rvalid"}, 32'(csr_rvalid), 32'(v));
        check({tag, ".rdata"}, csr_rdata, (v && legal) ? old_v : 32'd0);
        check({tag, ".illegal"}, 32'(csr_illegal), 32'(v && !legal));
        check_state(tag);
        check({tag, ".fs_dirty"}, 32'(fs_dirty), 32'(fcsr_m != prev));
    endtask

    task automatic check_rm(input string tag, input logic [2:0] rm);
        int exp_rm;
        instr_rm = rm;
        #1;
        exp_rm = (rm == 3'd7) ? int'(fcsr_m[7:5]) : int'(rm);
        check({tag, ".rm_out"}, 32'(rm_out), 32'(exp_rm));
        check({tag, ".rm_illegal"}, 32'(rm_illegal), 32'(exp_rm >= 5));
    endtask

    initial begin
        logic [11:0] ra;
        // Reset held, then released on a falling edge
        repeat (3) @(posedge clock);
        #1;
        check("rst.rvalid", 32'(csr_rvalid), 32'd0);
        check("rst.fs_dirty", 32'(fs_dirty), 32'd0);
        check("rst.reserved", 32'(reserved), 32'd0);
        check_state("rst");
        @(negedge clock);
        reset = 1'b1;

        // Read fcsr after reset
        step("rd0", 1, 12'h003, 3'd2, 32'd0, 0, 5'd0);
        check("rd0.const", csr_rdata, 32'd0);

        // Write 0xFF to fcsr, read it back, dynamic rm = frm = 7
        step("wr_ff", 1, 12'h003, 3'd1, 32'hFF, 0, 5'd0);
        check("wr_ff.dirty_const", 32'(fs_dirty), 32'd1);
        step("rd_ff", 1, 12'h003, 3'd2, 32'd0, 0, 5'd0);
        check("rd_ff.const", csr_rdata, 32'hFF);
        check("rd_ff.dirty_once", 32'(fs_dirty), 32'd0);
        check_rm("rm7", 3'd7);
        check_rm("rm1", 3'd1);

        // Sticky accumulation, then clear-immediate NX
        step("clr", 1, 12'h001, 3'd1, 32'd0, 0, 5'd0);
        step("fpu_nx", 0, 12'h000, 3'd0, 32'd0, 1, 5'b00001);
        step("fpu_nv", 0, 12'h000, 3'd0, 32'd0, 1, 5'b10000);
        check("acc.const", 32'({NV, DZ, OF, UF, NX}), 32'h11);
        step("rci", 1, 12'h001, 3'd7, 32'd1, 0, 5'd0);
        check("rci.rdata_const", csr_rdata, 32'h11);
        check("rci.flags_const", 32'({NV, DZ, OF, UF, NX}), 32'h10);

        // CSR write and FPU retire in the same cycle
        step("same", 1, 12'h001, 3'd1, 32'd0, 1, 5'b00100);
        check("same.rdata_const", csr_rdata, 32'h10);
        check("same.flags_const", 32'({NV, DZ, OF, UF, NX}), 32'h04);

        // Illegal address / op, and set with zero operand
        step("bad_addr", 1, 12'h004, 3'd1, 32'hFF, 0, 5'd0);
        step("bad_op", 1, 12'h003, 3'd4, 32'hFF, 0, 5'd0);
        step("rs_zero", 1, 12'h002, 3'd2, 32'd0, 0, 5'd0);

        // Back-to-back write then read of frm
        step("rwi", 1, 12'h002, 3'd5, 32'd3, 0, 5'd0);
        step("rd_frm", 1, 12'h002, 3'd2, 32'd0, 0, 5'd0);
        check("rd_frm.const", csr_rdata, 32'd3);

        // Reset mid-stream: a request just sampled, response then cleared
        @(negedge clock);
        csr_valid = 1; csr_addr = 12'h002; csr_op = 3'd2; csr_wdata = 0;
        @(posedge clock);
        #1;
        check("mid.rvalid_before", 32'(csr_rvalid), 32'd1);
        reset = 1'b0;
        fcsr_m = 8'h00;
        #1;
        check("mid.frm_async", 32'(frm), 32'd0);
        check("mid.rvalid_async", 32'(csr_rvalid), 32'd0);
        @(posedge clock);
        #1;
        check("mid.rvalid_held", 32'(csr_rvalid), 32'd0);
        check("mid.fs_dirty", 32'(fs_dirty), 32'd0);
        @(negedge clock);
        csr_valid = 0;
        reset = 1'b1;
        step("post_rst", 0, 12'h000, 3'd0, 32'd0, 0, 5'd0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0: ra = 12'h001;
                1: ra = 12'h002;
                2: ra = 12'h003;
                3: ra = 12'h004;
                4: ra = 12'h000;
                default: ra = 12'($urandom);
            endcase
            step("rnd", 1'($urandom_range(0, 3) != 0), ra, 3'($urandom),
                 ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom),
                 1'($urandom), 5'($urandom));
            check_rm("rnd_rm", 3'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
